sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter BurstLengthSDRAM, default 8, beats per burst (power of two, >=2).
REQ-002 SHALL have parameter PixelBitWidth, default 16, data beat width.
REQ-003 SHALL have parameter AddressWidthSDRAM, default 24, word address width.
REQ-004 SHALL have parameter MaxReadStreak, default 4, consecutive read grants allowed while write waits.
REQ-005 SHALL have ports: CLK input 1, sole clock; RST input 1, asynchronous active-high reset.
REQ-006 SHALL have write-requester ports: i_wr_req input 1; i_wr_addr input AddressWidthSDRAM; i_wr_data input PixelBitWidth; o_wr_gnt output 1; o_wr_data_ack output 1, beat consumed.
REQ-007 SHALL have read-requester ports: i_rd_req input 1; i_rd_addr input AddressWidthSDRAM; o_rd_gnt output 1; o_rd_data output PixelBitWidth; o_rd_data_valid output 1.
REQ-008 SHALL have SDRAM-side ports: o_sdram_cmd_valid output 1; i_sdram_cmd_ready input 1; o_sdram_cmd_wr output 1; o_sdram_addr output AddressWidthSDRAM; o_sdram_wdata output PixelBitWidth; i_sdram_valid_wr input 1, write beat strobe; i_sdram_rdata input PixelBitWidth; i_sdram_rdata_valid input 1.
REQ-009 SHALL have o_busy output 1, high whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, CMD, DATA, DONE.
REQ-011 IDLE: with any request, SHALL pick a winner, latch address with low log2(BurstLengthSDRAM) bits forced to 0, latch direction, assert winner's gnt next cycle, go CMD.
REQ-012 Priority: read wins ties unless streak counter == MaxReadStreak and i_wr_req high, then write wins.
REQ-013 Streak counter SHALL increment on each read grant while i_wr_req high, saturate at MaxReadStreak, clear on any write grant or when i_wr_req low at arbitration.
REQ-014 CMD: o_sdram_cmd_valid high with stable addr/direction until cycle where i_sdram_cmd_ready high; then DATA, cmd_valid low next cycle.
REQ-015 DATA write: o_sdram_wdata = i_wr_data combinationally; o_wr_data_ack = i_sdram_valid_wr; each strobe counts one beat.
REQ-016 DATA read: o_rd_data/o_rd_data_valid SHALL be i_sdram_rdata/i_sdram_rdata_valid registered one cycle; each valid counts one beat.
REQ-017 After beat BurstLengthSDRAM, SHALL go DONE; beat counter width log2(BurstLengthSDRAM)+1, cleared on entry to CMD.
REQ-018 DONE: SHALL drop gnt, stay one cycle, return IDLE; back-to-back bursts therefore have >=1 IDLE cycle.
REQ-019 gnt SHALL stay high from CMD entry through DATA; requester deasserting req mid-burst SHALL NOT abort it.
REQ-020 Strobes of the wrong direction (rdata_valid during write, valid_wr during read) or outside DATA SHALL be ignored and not counted.
REQ-021 o_wr_gnt and o_rd_gnt SHALL never be high simultaneously.

Reset
REQ-022 RST high SHALL immediately force state IDLE, counters 0, and all outputs 0 (gnts, cmd_valid, cmd_wr, addr, rd_data, rd_data_valid, busy).
REQ-023 Reset mid-burst SHALL abandon the burst without completion; the SDRAM controller shares RST.

Structure
REQ-024 State encodings and the alignment-mask helper SHALL live in shared package sdram_pkg.
REQ-025 Priority/streak logic SHALL be one sub-module, sdram_arb_priority; rest is a single FSM.

Verification
REQ-026 Only i_wr_req, addr 0x000013, cmd_ready immediate -> o_sdram_addr 0x000010, cmd_wr 1, 8 wdata acks, o_wr_gnt falls in DONE.
REQ-027 wr and rd req same cycle, streak 0 -> read granted first, write granted after read DONE+IDLE.
REQ-028 Both held continuously -> grant order R,R,R,R,W,R,R,R,R,W.
REQ-029 cmd_ready held low 5 cycles -> cmd_valid and addr stable 5 cycles, no beats counted.
REQ-030 RST asserted at read beat 3 -> outputs 0 same cycle, next arbitration restarts with beat count 0.
REQ-031 rdata_valid pulsed during write burst -> ignored; write completes after exactly 8 valid_wr strobes.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter: FSM state encoding and the
// helper that aligns a word address to the start of a burst.
package sdram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // burst_len must be a power of two; clears the in-burst offset bits.
    function automatic logic [63:0] align_burst(input logic [63:0] addr,
                                                input int unsigned burst_len);
        return addr & ~(64'(burst_len) - 64'd1);
    endfunction

endpackage

// File: rtl/sdram_arb_priority.sv
// Read-biased priority picker with a bounded read streak so a waiting
// writer is guaranteed a grant after MaxReadStreak consecutive reads.
module sdram_arb_priority #(
    parameter int MaxReadStreak = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_wr_req,
    input  logic i_rd_req,
    input  logic i_arb,
    output logic o_pick_wr
);

    localparam int SW = (MaxReadStreak < 1) ? 1 : $clog2(MaxReadStreak + 1);

    logic [SW-1:0] streak_q;
    logic          at_limit;

    assign at_limit  = (streak_q == SW'(MaxReadStreak));
    assign o_pick_wr = i_wr_req & (~i_rd_req | at_limit);

    // Streak only grows while a writer is actually being held off.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            streak_q <= '0;
        end else if (i_arb) begin
            if (o_pick_wr || !i_wr_req) begin
                streak_q <= '0;
            end else if (!at_limit) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester (write/read) burst arbiter in front of an SDRAM controller:
// arbitrates in IDLE, issues one command, counts burst beats, then releases.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int BurstLengthSDRAM  = 8,
    parameter int PixelBitWidth     = 16,
    parameter int AddressWidthSDRAM = 24,
    parameter int MaxReadStreak     = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         i_wr_req,
    input  logic [AddressWidthSDRAM-1:0] i_wr_addr,
    input  logic [PixelBitWidth-1:0]     i_wr_data,
    output logic                         o_wr_gnt,
    output logic                         o_wr_data_ack,
    input  logic                         i_rd_req,
    input  logic [AddressWidthSDRAM-1:0] i_rd_addr,
    output logic                         o_rd_gnt,
    output logic [PixelBitWidth-1:0]     o_rd_data,
    output logic                         o_rd_data_valid,
    output logic                         o_sdram_cmd_valid,
    input  logic                         i_sdram_cmd_ready,
    output logic                         o_sdram_cmd_wr,
    output logic [AddressWidthSDRAM-1:0] o_sdram_addr,
    output logic [PixelBitWidth-1:0]     o_sdram_wdata,
    input  logic                         i_sdram_valid_wr,
    input  logic [PixelBitWidth-1:0]     i_sdram_rdata,
    input  logic                         i_sdram_rdata_valid,
    output logic                         o_busy
);

    localparam int BW = $clog2(BurstLengthSDRAM) + 1;

    state_t                       state_q, state_d;
    logic [BW-1:0]                beat_q, beat_d;
    logic                         dir_wr_q;
    logic [AddressWidthSDRAM-1:0] addr_q;
    logic [PixelBitWidth-1:0]     rd_data_q;
    logic                         rd_valid_q;
    logic                         arb, pick_wr, beat_strobe, last_beat, in_data;

    sdram_arb_priority #(.MaxReadStreak(MaxReadStreak)) u_priority (
        .CLK       (CLK),
        .RST       (RST),
        .i_wr_req  (i_wr_req),
        .i_rd_req  (i_rd_req),
        .i_arb     (arb),
        .o_pick_wr (pick_wr)
    );

    assign arb     = (state_q == ST_IDLE) && (i_wr_req || i_rd_req);
    assign in_data = (state_q == ST_DATA);
    // Only strobes matching the latched direction advance the burst.
    assign beat_strobe = in_data && (dir_wr_q ? i_sdram_valid_wr : i_sdram_rdata_valid);
    assign last_beat   = beat_strobe && (beat_q == BW'(BurstLengthSDRAM - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (arb) begin
                    state_d = ST_CMD;
                    beat_d  = '0;
                end
            end
            ST_CMD: begin
                if (i_sdram_cmd_ready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (beat_strobe) beat_d = beat_q + 1'b1;
                if (last_beat) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            dir_wr_q   <= 1'b0;
            addr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rd_valid_q <= in_data && !dir_wr_q && i_sdram_rdata_valid;
            if (in_data && !dir_wr_q && i_sdram_rdata_valid) rd_data_q <= i_sdram_rdata;
            if (arb) begin
                dir_wr_q <= pick_wr;
                addr_q   <= AddressWidthSDRAM'(align_burst(
                                64'(pick_wr ? i_wr_addr : i_rd_addr), BurstLengthSDRAM));
            end
        end
    end

    assign o_wr_gnt          = (state_q == ST_CMD || in_data) && dir_wr_q;
    assign o_rd_gnt          = (state_q == ST_CMD || in_data) && !dir_wr_q;
    assign o_sdram_cmd_valid = (state_q == ST_CMD);
    assign o_sdram_cmd_wr    = dir_wr_q;
    assign o_sdram_addr      = addr_q;
    assign o_sdram_wdata     = i_wr_data;
    assign o_wr_data_ack     = in_data && dir_wr_q && i_sdram_valid_wr;
    assign o_rd_data         = rd_data_q;
    assign o_rd_data_valid   = rd_valid_q;
    assign o_busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: an SDRAM-side responder drives command
// ready and data strobes; read data is checked through an expected queue.
module tb_sdram_arbiter;

    localparam int BL = 8;
    localparam int PW = 16;
    localparam int AW = 24;

    logic          CLK, RST;
    logic          i_wr_req, o_wr_gnt, o_wr_data_ack;
    logic [AW-1:0] i_wr_addr, i_rd_addr, o_sdram_addr;
    logic [PW-1:0] i_wr_data, o_rd_data, o_sdram_wdata, i_sdram_rdata;
    logic          i_rd_req, o_rd_gnt, o_rd_data_valid;
    logic          o_sdram_cmd_valid, i_sdram_cmd_ready, o_sdram_cmd_wr;
    logic          i_sdram_valid_wr, i_sdram_rdata_valid, o_busy;

    int n_vec  = 0;
    int n_miss = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] wexp_q[$];

    sdram_arbiter #(
        .BurstLengthSDRAM(BL), .PixelBitWidth(PW),
        .AddressWidthSDRAM(AW), .MaxReadStreak(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .o_wr_gnt(o_wr_gnt), .o_wr_data_ack(o_wr_data_ack),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_gnt(o_rd_gnt),
        .o_rd_data(o_rd_data), .o_rd_data_valid(o_rd_data_valid),
        .o_sdram_cmd_valid(o_sdram_cmd_valid), .i_sdram_cmd_ready(i_sdram_cmd_ready),
        .o_sdram_cmd_wr(o_sdram_cmd_wr), .o_sdram_addr(o_sdram_addr),
        .o_sdram_wdata(o_sdram_wdata), .i_sdram_valid_wr(i_sdram_valid_wr),
        .i_sdram_rdata(i_sdram_rdata), .i_sdram_rdata_valid(i_sdram_rdata_valid),
        .o_busy(o_busy)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (!RST) check("gnt_exclusive", {31'd0, o_wr_gnt & o_rd_gnt}, 32'd0);
        if (o_rd_data_valid) begin
            if (exp_q.size() == 0) check("rd_unexpected", {31'd0, o_rd_data_valid}, 32'd0);
            else                   check("rd_data", {16'd0, o_rd_data}, {16'd0, exp_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs();
        check("rst_wr_gnt", {31'd0, o_wr_gnt}, 32'd0);
        check("rst_rd_gnt", {31'd0, o_rd_gnt}, 32'd0);
        check("rst_cmd_valid", {31'd0, o_sdram_cmd_valid}, 32'd0);
        check("rst_cmd_wr", {31'd0, o_sdram_cmd_wr}, 32'd0);
        check("rst_addr", {8'd0, o_sdram_addr}, 32'd0);
        check("rst_rd_data", {16'd0, o_rd_data}, 32'd0);
        check("rst_rd_valid", {31'd0, o_rd_data_valid}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic wait_gnt(output logic is_wr);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(o_wr_gnt || o_rd_gnt) && n < 40);
        check("gnt_timeout", {31'd0, o_wr_gnt | o_rd_gnt}, 32'd1);
        is_wr = o_wr_gnt;
    endtask

    task automatic do_burst(input logic exp_wr, input logic [AW-1:0] exp_addr,
                            input int rdy_delay, input bit drop_req, input bit noise);
        logic          is_wr;
        logic [PW-1:0] d;
        int            b, guard;
        wait_gnt(is_wr);
        check("grant_dir", {31'd0, is_wr}, {31'd0, exp_wr});
        if (drop_req) begin
            if (exp_wr) i_wr_req = 1'b0;
            else        i_rd_req = 1'b0;
        end
        check("cmd_valid", {31'd0, o_sdram_cmd_valid}, 32'd1);
        check("cmd_addr", {8'd0, o_sdram_addr}, {8'd0, exp_addr});
        check("cmd_wr", {31'd0, o_sdram_cmd_wr}, {31'd0, exp_wr});
        check("busy_cmd", {31'd0, o_busy}, 32'd1);
        for (int i = 0; i < rdy_delay; i++) begin
            i_sdram_cmd_ready   = 1'b0;
            i_sdram_valid_wr    = noise;
            i_sdram_rdata_valid = noise;
            #1;
            check("ack_in_cmd", {31'd0, o_wr_data_ack}, 32'd0);
            @(negedge CLK);
            check("cmd_valid_hold", {31'd0, o_sdram_cmd_valid}, 32'd1);
            check("cmd_addr_hold", {8'd0, o_sdram_addr}, {8'd0, exp_addr});
        end
        i_sdram_valid_wr    = 1'b0;
        i_sdram_rdata_valid = 1'b0;
        i_sdram_cmd_ready   = 1'b1;
        @(negedge CLK);
        i_sdram_cmd_ready = 1'b0;
        check("cmd_valid_drop", {31'd0, o_sdram_cmd_valid}, 32'd0);
        b = 0;
        guard = 0;
        while (b < BL && guard < 100) begin
            guard++;
            check("gnt_hold", {31'd0, exp_wr ? o_wr_gnt : o_rd_gnt}, 32'd1);
            if ($urandom_range(0, 3) == 0) begin
                i_sdram_valid_wr    = exp_wr ? 1'b0 : noise;
                i_sdram_rdata_valid = exp_wr ? noise : 1'b0;
                #1;
                check("ack_gap", {31'd0, o_wr_data_ack}, 32'd0);
            end else if (exp_wr) begin
                d = PW'($urandom);
                i_wr_data           = d;
                i_sdram_valid_wr    = 1'b1;
                i_sdram_rdata_valid = noise;
                wexp_q.push_back(d);
                #1;
                check("wr_ack", {31'd0, o_wr_data_ack}, 32'd1);
                check("wr_wdata", {16'd0, o_sdram_wdata}, {16'd0, wexp_q.pop_front()});
                b++;
            end else begin
                d = PW'($urandom);
                i_sdram_rdata       = d;
                i_sdram_rdata_valid = 1'b1;
                i_sdram_valid_wr    = noise;
                exp_q.push_back(d);
                #1;
                check("rd_no_wack", {31'd0, o_wr_data_ack}, 32'd0);
                b++;
            end
            @(negedge CLK);
        end
        i_sdram_valid_wr    = 1'b0;
        i_sdram_rdata_valid = 1'b0;
        check("done_wr_gnt", {31'd0, o_wr_gnt}, 32'd0);
        check("done_rd_gnt", {31'd0, o_rd_gnt}, 32'd0);
        check("done_busy", {31'd0, o_busy}, 32'd1);
        @(negedge CLK);
        check("idle_busy", {31'd0, o_busy}, 32'd0);
        check("idle_gnt", {31'd0, o_wr_gnt | o_rd_gnt}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic          is_wr;
        logic [9:0]    pat;
        logic [AW-1:0] wa, ra;

        RST = 1'b1;
        i_wr_req = 1'b0; i_rd_req = 1'b0;
        i_wr_addr = '0; i_rd_addr = '0; i_wr_data = '0;
        i_sdram_cmd_ready = 1'b0; i_sdram_valid_wr = 1'b0;
        i_sdram_rdata = '0; i_sdram_rdata_valid = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Lone write, unaligned address, writer drops request after grant.
        i_wr_addr = 24'h000013;
        i_wr_req  = 1'b1;
        do_burst(1'b1, 24'h000010, 0, 1'b1, 1'b0);

        // Simultaneous requests with empty streak: read first, then write.
        wa = AW'($urandom); ra = AW'($urandom);
        i_wr_addr = wa; i_rd_addr = ra;
        i_wr_req = 1'b1; i_rd_req = 1'b1;
        do_burst(1'b0, ra & ~AW'(BL - 1), 0, 1'b1, 1'b0);
        do_burst(1'b1, wa & ~AW'(BL - 1), 0, 1'b1, 1'b0);

        // Both held continuously: read streak capped at four.
        pat = 10'b1000010000;
        i_wr_req = 1'b1; i_rd_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 9) do_burst(pat[k], pat[k] ? (wa & ~AW'(BL - 1)) : (ra & ~AW'(BL - 1)), 0, 1'b1, 1'b0);
            else        do_burst(pat[k], pat[k] ? (wa & ~AW'(BL - 1)) : (ra & ~AW'(BL - 1)), 0, 1'b0, 1'b0);
        end
        i_wr_req = 1'b0; i_rd_req = 1'b0;

        // Command held off five cycles with stray strobes in CMD.
        i_wr_addr = 24'h12345F; i_wr_req = 1'b1;
        do_burst(1'b1, 24'h123458, 5, 1'b1, 1'b1);

        // Write burst with read-valid noise throughout.
        i_wr_addr = 24'hABCDE7; i_wr_req = 1'b1;
        do_burst(1'b1, 24'hABCDE0, 1, 1'b1, 1'b1);

        // Reset in the middle of a read burst.
        i_rd_addr = 24'h00F00D; i_rd_req = 1'b1;
        wait_gnt(is_wr);
        check("rst_burst_dir", {31'd0, is_wr}, 32'd0);
        i_rd_req = 1'b0;
        i_sdram_cmd_ready = 1'b1;
        @(negedge CLK);
        i_sdram_cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_sdram_rdata = PW'($urandom);
            i_sdram_rdata_valid = 1'b1;
            exp_q.push_back(i_sdram_rdata);
            @(negedge CLK);
        end
        i_sdram_rdata_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // Fresh read after reset must need a full burst; write strobes as noise.
        i_rd_addr = 24'h00F00D; i_rd_req = 1'b1;
        do_burst(1'b0, 24'h00F008, 2, 1'b1, 1'b1);
        repeat (2) @(negedge CLK);
        check("final_idle_busy", {31'd0, o_busy}, 32'd0);
        check("rd_queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
